vga_line_sched: RTL and testbench

Arbitration and sequencing controller for the Bresenham line engine in the VGA game datapath. Two game-logic requesters submit line segments. The block grants them round-robin and normalises endpoints to the engine's single supported octant (x increasing, 0 ≤ slope ≤ 1). It rejects segments the engine cannot draw, launches the engine with a start pulse, and supervises completion with a watchdog.

---
 rtl/vga_line_sched.sv | 164 ++++++++++++++++
 tb/tb_vga_line_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_sched.sv
// vga_line_sched: round-robin arbiter and sequencer for the Bresenham line engine.
// Grants one of two requesters, normalises the segment to the engine's single
// octant (x increasing, 0 <= slope <= 1), rejects undrawable segments, launches
// the engine and supervises completion with a watchdog.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; arbitrates when not paused
// CHECK | captured segment normalised and classified
// WAIT  | engine drawing; waiting for eng_done or watchdog expiry
module vga_line_sched #(
    parameter int CW      = 20,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk_65M,
    input  logic          clear,
    input  logic          pause,
    input  logic          req0,
    input  logic          req1,
    input  logic [CW-1:0] x1_0,
    input  logic [CW-1:0] y1_0,
    input  logic [CW-1:0] x2_0,
    input  logic [CW-1:0] y2_0,
    input  logic [CW-1:0] x1_1,
    input  logic [CW-1:0] y1_1,
    input  logic [CW-1:0] x2_1,
    input  logic [CW-1:0] y2_1,
    output logic          ack0,
    output logic          ack1,
    output logic          rej,
    output logic          done,
    output logic          grant_id,
    output logic          busy,
    output logic          err,
    output logic          eng_start,
    output logic [CW-1:0] eng_x1,
    output logic [CW-1:0] eng_y1,
    output logic [CW-1:0] eng_x2,
    output logic [CW-1:0] eng_y2,
    input  logic          eng_done
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, WAIT} state_t;

    state_t        state, state_next;
    logic          last_served;
    logic [WW-1:0] wdog;
    logic [CW-1:0] cap_x1, cap_y1, cap_x2, cap_y2;

    logic          grant_en, grant_sel, launch, reject, finish, expire;
    logic          swap, bad;
    logic [CW-1:0] nx1, ny1, nx2, ny2;
    logic signed [CW:0] dx, dy;

    // Normalise the captured segment and classify it against the engine's octant.
    always_comb begin
        swap = (cap_x2 < cap_x1);
        nx1  = swap ? cap_x2 : cap_x1;
        ny1  = swap ? cap_y2 : cap_y1;
        nx2  = swap ? cap_x1 : cap_x2;
        ny2  = swap ? cap_y1 : cap_y2;
        dx   = $signed({1'b0, nx2}) - $signed({1'b0, nx1});
        dy   = $signed({1'b0, ny2}) - $signed({1'b0, ny1});
        bad  = dy[CW] || (dy > dx);
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        grant_sel  = 1'b0;
        launch     = 1'b0;
        reject     = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (!pause && (req0 || req1)) begin
                    grant_en   = 1'b1;
                    grant_sel  = (req0 && req1) ? ~last_served : req1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (bad) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else begin
                    launch     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Completion takes priority over a coincident watchdog expiry.
                if (eng_done) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (wdog == '0) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    // Registered outputs, captured coordinates and the watchdog down-counter.
    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rej         <= 1'b0;
            done        <= 1'b0;
            eng_start   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            grant_id    <= 1'b0;
            last_served <= 1'b1;
            wdog        <= '0;
            cap_x1      <= '0;
            cap_y1      <= '0;
            cap_x2      <= '0;
            cap_y2      <= '0;
            eng_x1      <= '0;
            eng_y1      <= '0;
            eng_x2      <= '0;
            eng_y2      <= '0;
        end else begin
            ack0      <= grant_en & ~grant_sel;
            ack1      <= grant_en & grant_sel;
            rej       <= reject;
            done      <= finish;
            eng_start <= launch;
            busy      <= (state_next != IDLE);
            err       <= err | expire;
            if (grant_en) begin
                grant_id    <= grant_sel;
                last_served <= grant_sel;
                cap_x1      <= grant_sel ? x1_1 : x1_0;
                cap_y1      <= grant_sel ? y1_1 : y1_0;
                cap_x2      <= grant_sel ? x2_1 : x2_0;
                cap_y2      <= grant_sel ? y2_1 : y2_0;
            end
            if (launch) begin
                eng_x1 <= nx1;
                eng_y1 <= ny1;
                eng_x2 <= nx2;
                eng_y2 <= ny2;
                wdog   <= WW'(TIMEOUT - 1);
            end else if (state == WAIT && wdog != '0) begin
                wdog <= wdog - WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_line_sched.sv
// Directed testbench for vga_line_sched with hand-computed expectations.
module tb_vga_line_sched;

    localparam int CW      = 20;
    localparam int TIMEOUT = 16;

    logic          clk_65M = 1'b0;
    logic          clear, pause, req0, req1, eng_done;
    logic [CW-1:0] x1_0, y1_0, x2_0, y2_0, x1_1, y1_1, x2_1, y2_1;
    logic          ack0, ack1, rej, done, grant_id, busy, err, eng_start;
    logic [CW-1:0] eng_x1, eng_y1, eng_x2, eng_y2;

    int n_checks = 0;
    int n_pass   = 0;

    vga_line_sched #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk_65M(clk_65M), .clear(clear), .pause(pause),
        .req0(req0), .req1(req1),
        .x1_0(x1_0), .y1_0(y1_0), .x2_0(x2_0), .y2_0(y2_0),
        .x1_1(x1_1), .y1_1(y1_1), .x2_1(x2_1), .y2_1(y2_1),
        .ack0(ack0), .ack1(ack1), .rej(rej), .done(done),
        .grant_id(grant_id), .busy(busy), .err(err), .eng_start(eng_start),
        .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_x2(eng_x2), .eng_y2(eng_y2),
        .eng_done(eng_done)
    );

    always #5 clk_65M = ~clk_65M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_65M);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #2;
        clear = 1'b0;
    endtask

    task automatic set_seg(input bit who, input int a, input int b, input int c, input int d);
        if (who) begin
            x1_1 = CW'(a); y1_1 = CW'(b); x2_1 = CW'(c); y2_1 = CW'(d);
        end else begin
            x1_0 = CW'(a); y1_0 = CW'(b); x2_0 = CW'(c); y2_0 = CW'(d);
        end
    endtask

    // Raise one request, check the ack cycle, then drop the request.
    task automatic issue(input string tag, input bit who, input int a, input int b, input int c, input int d);
        set_seg(who, a, b, c, d);
        if (who) req1 = 1'b1; else req0 = 1'b1;
        tick();
        check({tag, "_ack0"}, ack0, !who);
        check({tag, "_ack1"}, ack1, who);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_gid"}, grant_id, who);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic expect_launch(input string tag, input int a, input int b, input int c, input int d);
        tick();
        check({tag, "_start"}, eng_start, 1);
        check({tag, "_rej"}, rej, 0);
        check({tag, "_x1"}, eng_x1, a);
        check({tag, "_y1"}, eng_y1, b);
        check({tag, "_x2"}, eng_x2, c);
        check({tag, "_y2"}, eng_y2, d);
    endtask

    task automatic expect_reject(input string tag);
        tick();
        check({tag, "_rej"}, rej, 1);
        check({tag, "_start"}, eng_start, 0);
        check({tag, "_busy"}, busy, 0);
        tick();
        check({tag, "_rej_off"}, rej, 0);
    endtask

    task automatic finish_seg(input string tag);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        int ack_seen;
        clear = 1'b1; pause = 1'b0; req0 = 1'b0; req1 = 1'b0; eng_done = 1'b0;
        set_seg(0, 0, 0, 0, 0);
        set_seg(1, 0, 0, 0, 0);
        #12;
        clear = 1'b0;
        tick();

        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_gid", grant_id, 0);
        check("rst_start", eng_start, 0);
        check("rst_ack", {ack0, ack1, rej, done}, 0);
        check("rst_engx1", eng_x1, 0);

        // Single request, long engine run.
        issue("single", 0, 10, 20, 110, 70);
        expect_launch("single", 10, 20, 110, 70);
        tick();
        check("single_start_pulse", eng_start, 0);
        repeat (8) tick();
        check("single_hold_x2", eng_x2, 110);
        check("single_busy_wait", busy, 1);
        finish_seg("single");
        tick();
        check("single_done_pulse", done, 0);

        // Swapped endpoints from requester 1.
        issue("swap", 1, 300, 90, 100, 40);
        expect_launch("swap", 100, 40, 300, 90);
        finish_seg("swap");

        // Rejects and octant boundaries.
        issue("rej_steep", 0, 0, 0, 10, 20);
        expect_reject("rej_steep");
        issue("rej_neg", 0, 0, 50, 100, 10);
        expect_reject("rej_neg");
        issue("rej_edge", 1, 0, 0, 5, 6);
        expect_reject("rej_edge");
        issue("diag", 0, 0, 0, 5, 5);
        expect_launch("diag", 0, 0, 5, 5);
        finish_seg("diag");
        issue("point", 1, 7, 7, 7, 7);
        expect_launch("point", 7, 7, 7, 7);
        finish_seg("point");
        issue("horiz", 0, 50, 9, 20, 9);
        expect_launch("horiz", 20, 9, 50, 9);
        finish_seg("horiz");

        // Round-robin from reset with both requests held.
        pulse_clear();
        set_seg(0, 0, 0, 10, 5);
        set_seg(1, 0, 0, 20, 3);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_ack0", ack0, (i % 2) == 0);
            check("rr_ack1", ack1, (i % 2) == 1);
            check("rr_gid", grant_id, i % 2);
            tick();
            check("rr_start", eng_start, 1);
            check("rr_x2", eng_x2, (i % 2) ? 20 : 10);
            repeat (4) tick();
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            check("rr_done", done, 1);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        check("rr_idle", busy, 0);

        // Pause holds off the grant.
        pause = 1'b1;
        set_seg(0, 1, 1, 9, 2);
        req0 = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack0 || ack1 || busy) ack_seen++;
        end
        check("pause_no_ack", ack_seen, 0);
        pause = 1'b0;
        tick();
        check("pause_release_ack", ack0, 1);
        req0 = 1'b0;
        expect_launch("wd", 1, 1, 9, 2);

        // Watchdog expiry after TIMEOUT cycles in WAIT.
        repeat (TIMEOUT - 1) tick();
        check("wd_err_early", err, 0);
        check("wd_busy_early", busy, 1);
        tick();
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        check("wd_no_done", done, 0);
        repeat (3) tick();
        check("wd_sticky", err, 1);

        // eng_done coincident with expiry.
        pulse_clear();
        check("clr_err", err, 0);
        issue("coin", 0, 2, 2, 12, 4);
        expect_launch("coin", 2, 2, 12, 4);
        repeat (TIMEOUT - 1) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("coin_done", done, 1);
        check("coin_err", err, 0);

        // Asynchronous clear in WAIT.
        issue("aclr", 1, 5, 5, 15, 6);
        expect_launch("aclr", 5, 5, 15, 6);
        #2;
        clear = 1'b1;
        #1;
        check("aclr_busy", busy, 0);
        check("aclr_start", eng_start, 0);
        check("aclr_gid", grant_id, 0);
        check("aclr_x1", eng_x1, 0);
        clear = 1'b0;
        tick();
        issue("post", 0, 3, 4, 30, 8);
        expect_launch("post", 3, 4, 30, 8);
        finish_seg("post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
